// File: rtl/jelly2_img_filter2d_calc_mc_pkg.sv
// Shared types and helpers for the multi-channel 2D filter arithmetic core.
package jelly2_img_filter2d_pkg;

  typedef enum logic {
    ROUND_TRUNC   = 1'b0,
    ROUND_HALF_UP = 1'b1
  } round_t;

  // Enabled-cycle latency from s_* to m_*, for blocks that delay sideband signals alongside.
  function automatic int filter2d_latency(input int rows, input int cols);
    return $clog2(rows * cols) + 4;
  endfunction

endpackage

// File: rtl/jelly2_img_filter2d_calc_mc_if.sv
// Pixel stream bundle (first/data/valid) used on both sides of the filter core.
interface jelly2_img_filter2d_calc_mc_if #(
  parameter int DATA_BITS = 8
);
  logic                 first;
  logic [DATA_BITS-1:0] data;
  logic                 valid;

  modport master (output first, data, valid);
  modport slave  (input  first, data, valid);
endinterface

// File: rtl/jelly2_img_filter2d_mac.sv
// One channel of the filter: multipliers, registered adder tree, round/shift and clamp.
module jelly2_img_filter2d_mac
  import jelly2_img_filter2d_pkg::*;
#(
  parameter int N           = 9,
  parameter int DATA_WIDTH  = 8,
  parameter int COEFF_WIDTH = 18,
  parameter int COEFF_FRAC  = 16,
  parameter int MAC_WIDTH   = 30,
  parameter bit SIGNED      = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cke,
  input  logic [N*COEFF_WIDTH-1:0] coeff,
  input  logic [N*DATA_WIDTH-1:0]  data,
  input  logic [DATA_WIDTH-1:0]    param_min,
  input  logic [DATA_WIDTH-1:0]    param_max,
  input  logic                     param_round,
  output logic [DATA_WIDTH-1:0]    out_data
);
  localparam int CALC_WIDTH = SIGNED ? DATA_WIDTH : DATA_WIDTH + 1;
  localparam int LEVELS     = $clog2(N);
  localparam int PAIRS      = (N + 1) / 2;

  typedef logic signed [MAC_WIDTH-1:0] mac_t;
  localparam mac_t HALF = mac_t'(1'b1) << (COEFF_FRAC - 1);

  function automatic mac_t ext_sample(input logic [DATA_WIDTH-1:0] x);
    logic [CALC_WIDTH-1:0] c;
    if (SIGNED) c = CALC_WIDTH'(signed'(x));
    else        c = CALC_WIDTH'(x);
    return mac_t'(signed'(c));
  endfunction

  // Operand count at a tree level; odd leftovers pass through to the next level.
  function automatic int level_count(input int lvl);
    return (N + (1 << lvl) - 1) >> lvl;
  endfunction

  mac_t                  tree_q [LEVELS+1][N+1];
  mac_t                  shift_q, shift_d, round_add, lo, hi, t;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  round_t                round_mode;

  always_comb begin
    round_mode = round_t'(param_round);
    if (round_mode == ROUND_HALF_UP) round_add = HALF;
    else                             round_add = '0;
    shift_d = (tree_q[LEVELS][0] + round_add) >>> COEFF_FRAC;
    if (SIGNED) begin
      lo = mac_t'(signed'(param_min));
      hi = mac_t'(signed'(param_max));
    end else begin
      lo = mac_t'({1'b0, param_min});
      hi = mac_t'({1'b0, param_max});
    end
    // Lower bound first, then upper: with min > max the upper bound wins.
    if (shift_q < lo) t = lo;
    else              t = shift_q;
    if (t > hi) out_d = hi[DATA_WIDTH-1:0];
    else        out_d = t[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int l = 0; l <= LEVELS; l++) begin
        for (int i = 0; i <= N; i++) tree_q[l][i] <= '0;
      end
      shift_q <= '0;
      out_q   <= '0;
    end else if (cke) begin
      for (int k = 0; k < N; k++) begin
        tree_q[0][k] <= ext_sample(data[k*DATA_WIDTH +: DATA_WIDTH])
                        * mac_t'(signed'(coeff[k*COEFF_WIDTH +: COEFF_WIDTH]));
      end
      for (int l = 1; l <= LEVELS; l++) begin
        for (int i = 0; i < PAIRS; i++) begin
          if (2*i + 1 < level_count(l - 1))  tree_q[l][i] <= tree_q[l-1][2*i] + tree_q[l-1][2*i+1];
          else if (2*i < level_count(l - 1)) tree_q[l][i] <= tree_q[l-1][2*i];
          else                               tree_q[l][i] <= '0;
        end
      end
      shift_q <= shift_d;
      out_q   <= out_d;
    end
  end

  assign out_data = out_q;

endmodule

// File: rtl/jelly2_img_filter2d_calc_mc.sv
// Multi-channel 2D filter core: input register, frame-synchronous kernel update,
// sideband delay line and one MAC pipeline per channel.
module jelly2_img_filter2d_calc_mc
  import jelly2_img_filter2d_pkg::*;
#(
  parameter int ROWS        = 3,
  parameter int COLS        = 3,
  parameter int CHANNELS    = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int COEFF_WIDTH = 18,
  parameter int COEFF_FRAC  = 16,
  parameter int MAC_WIDTH   = DATA_WIDTH + COEFF_WIDTH + $clog2(ROWS * COLS),
  parameter bit SIGNED      = 1'b0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cke,
  input  logic [ROWS*COLS*COEFF_WIDTH-1:0]  param_coeff,
  input  logic [DATA_WIDTH-1:0]             param_min,
  input  logic [DATA_WIDTH-1:0]             param_max,
  input  logic                              param_round,
  input  logic                              param_update,
  output logic                              update_pending,
  jelly2_img_filter2d_calc_mc_if.slave      s,
  jelly2_img_filter2d_calc_mc_if.master     m
);
  localparam int N   = ROWS * COLS;
  localparam int LAT = filter2d_latency(ROWS, COLS);

  logic                          load;
  logic                          pending_q, pending_d;
  logic [N*COEFF_WIDTH-1:0]      kernel_q, kernel_d;
  logic [N*CHANNELS*DATA_WIDTH-1:0] data_q;
  logic [LAT-1:0]                valid_q, first_q;
  logic [N*DATA_WIDTH-1:0]       chan_data [CHANNELS];
  logic [CHANNELS*DATA_WIDTH-1:0] mac_data;

  // A pending request is adopted on the first pixel of a frame; a new request on that edge wins.
  always_comb begin
    load      = cke && s.valid && s.first && pending_q;
    kernel_d  = load ? param_coeff : kernel_q;
    if (param_update) pending_d = 1'b1;
    else if (load)    pending_d = 1'b0;
    else              pending_d = pending_q;
  end

  // update_pending tracks every edge; the datapath registers advance only on cke.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= 1'b1;
      kernel_q  <= '0;
      data_q    <= '0;
      valid_q   <= '0;
      first_q   <= '0;
    end else begin
      pending_q <= pending_d;
      if (cke) begin
        kernel_q <= kernel_d;
        data_q   <= s.data;
        valid_q  <= {valid_q[LAT-2:0], s.valid};
        first_q  <= {first_q[LAT-2:0], s.first};
      end
    end
  end

  // Regroup the [row][col][ch] window into one tap vector per channel.
  always_comb begin
    chan_data = '{default: '0};
    for (int c = 0; c < CHANNELS; c++) begin
      for (int k = 0; k < N; k++) begin
        chan_data[c][k*DATA_WIDTH +: DATA_WIDTH] = data_q[(k*CHANNELS + c)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    jelly2_img_filter2d_mac #(
      .N           (N),
      .DATA_WIDTH  (DATA_WIDTH),
      .COEFF_WIDTH (COEFF_WIDTH),
      .COEFF_FRAC  (COEFF_FRAC),
      .MAC_WIDTH   (MAC_WIDTH),
      .SIGNED      (SIGNED)
    ) u_mac (
      .clk         (clk),
      .reset       (reset),
      .cke         (cke),
      .coeff       (kernel_q),
      .data        (chan_data[c]),
      .param_min   (param_min),
      .param_max   (param_max),
      .param_round (param_round),
      .out_data    (mac_data[c*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign update_pending = pending_q;
  assign m.valid        = valid_q[LAT-1];
  assign m.first        = first_q[LAT-1];
  assign m.data         = mac_data;

endmodule
